// File: rtl/i2s_tx_sample_feeder.sv
// Stereo FIFO feeding an I2S transmitter: accepts L/R pairs upstream, presents one pair
// per frame (advanced on the synchronised falling edge of ws), primes before playback.
module i2s_tx_sample_feeder #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 8,
  parameter int HOLD_LAST   = 0
) (
  input  logic                   mclk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_l,
  input  logic [WIDTH-1:0]       in_r,
  input  logic                   flush,
  input  logic                   ws,
  output logic [WIDTH-1:0]       tx_data_l,
  output logic [WIDTH-1:0]       tx_data_r,
  output logic [$clog2(DEPTH):0] level,
  output logic                   playing,
  output logic                   underrun,
  output logic [15:0]            underrun_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {PRIME = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic               empty, full, push, tick;
  logic               ws_q1, ws_q2;
  logic               pop, starve, fill;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [2*WIDTH-1:0] policy_pair(input logic [2*WIDTH-1:0] last);
    return (HOLD_LAST != 0) ? last : '0;
  endfunction

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level    = wr_ptr - rd_ptr;
  assign in_ready = rst_n && !full && !flush;
  assign push     = in_valid && in_ready;
  assign tick     = ws_q2 && !ws_q1;

  // ws synchroniser: a tick is the delayed falling edge, so both latch points see a stable pair
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      ws_q1 <= 1'b0;
      ws_q2 <= 1'b0;
    end else begin
      ws_q1 <= ws;
      ws_q2 <= ws_q1;
    end
  end

  always_ff @(posedge mclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_l, in_r};
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state <= PRIME;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = PRIME;
    end else begin
      case (state)
        PRIME:   if (level >= PW'(PRIME_LEVEL)) state_nxt = RUN;
        RUN:     if (tick && empty) state_nxt = PRIME;
        default: state_nxt = PRIME;
      endcase
    end
  end

  always_comb begin
    pop     = 1'b0;
    starve  = 1'b0;
    fill    = 1'b0;
    playing = (state == RUN);
    if (tick && !flush) begin
      if (state == PRIME) fill   = 1'b1;
      else if (empty)     starve = 1'b1;
      else                pop    = 1'b1;
    end
  end

  // flush leaves the presented pair untouched
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_l <= '0;
      tx_data_r <= '0;
    end else if (pop) begin
      {tx_data_l, tx_data_r} <= mem[rd_ptr[AW-1:0]];
    end else if (fill || starve) begin
      {tx_data_l, tx_data_r} <= policy_pair({tx_data_l, tx_data_r});
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (flush) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun <= starve;
      if (starve) underrun_cnt <= sat_inc(underrun_cnt);
    end
  end

endmodule

// File: doc/i2s_tx_sample_feeder.md
# i2s_tx_sample_feeder

Stereo sample buffer that sits directly upstream of the I2S transmitter. It accepts left/right sample pairs from the audio pipeline over a valid/ready handshake and stores them in a circular FIFO. It presents one pair on `tx_data_l`/`tx_data_r`, advancing once per I2S frame in lock-step with the transmitter's `ws`. It primes before playback and reports underruns.

## Interface
Parameters:
- `WIDTH`, 16, bits per channel sample
- `DEPTH`, 16, FIFO depth in stereo pairs; power of 2, ≥4
- `PRIME_LEVEL`, 8, pairs required before playback starts; range 1..DEPTH
- `HOLD_LAST`, 0, underrun/prime output policy: 0 = zeros, 1 = repeat last presented pair

Ports:
- `mclk`  in  1  main clock, same domain as the transmitter
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream pair valid
- `in_ready`  out  1  feeder can accept a pair
- `in_l`, `in_r`  in  WIDTH  upstream left/right sample
- `flush`  in  1  synchronous clear of FIFO, state and counter
- `ws`  in  1  word select from the transmitter; 1 = left channel
- `tx_data_l`, `tx_data_r`  out  WIDTH  pair presented to the transmitter
- `level`  out  $clog2(DEPTH)+1  stored pair count, 0..DEPTH
- `playing`  out  1  state == RUN
- `underrun`  out  1  one-cycle pulse per underrun frame
- `underrun_cnt`  out  16  saturating underrun count

## Operation
- FIFO: circular buffer with read and write pointers of $clog2(DEPTH)+1 bits; the extra bit is the wrap flag.
  - empty = pointers equal.
  - full = address bits equal and wrap bits differ.
  - `level` = wr − rd, modulo 2^($clog2(DEPTH)+1).
- Push: occurs when `in_valid && in_ready`. `in_ready` = !full && !flush.
  - A push while full is never accepted, even if a pop happens in the same cycle.
- Frame tick:
  - `ws` passes through two registers, ws_q1 and then ws_q2.
  - tick = ws_q2 & !ws_q1, i.e. a falling edge of `ws`, which marks the start of the right channel.
  - The transmitter latches both channels one edge after each `ws` toggle. Updating outputs on the delayed falling edge keeps each pair stable through both of its latch points (the rise and the fall).
- State machine, two states:
  - PRIME (reset state): on a tick, drive the pair selected by the policy; no pop, no underrun count. Go to RUN when `level` ≥ PRIME_LEVEL. This is evaluated every cycle, not only on ticks.
  - RUN: on a tick with the FIFO non-empty, pop the head pair into `tx_data_l/r`. On a tick with the FIFO empty, it is an underrun:
    - drive the pair selected by the policy;
    - pulse `underrun`;
    - increment `underrun_cnt`, saturating at 0xFFFF;
    - go to PRIME.
- Push and pop in the same cycle are both performed and `level` is unchanged. If the FIFO is empty on that cycle, the pop sees empty, so an underrun is taken and the pushed pair is stored.
- `flush`:
  - has priority over push and tick;
  - clears the pointers, `underrun_cnt` and the `underrun` pulse;
  - forces PRIME;
  - leaves `tx_data_l/r` unchanged.
- Arithmetic: samples are passed bit-exact, with no sign handling or scaling.

## Timing
- Reset values (asynchronous on `rst_n` low):
  - `tx_data_l/r` = 0, `level` = 0, `in_ready` = 0 while in reset, then 1.
  - `playing` = 0, `underrun` = 0, `underrun_cnt` = 0.
  - ws_q1 = ws_q2 = 0, so no spurious tick can follow reset.
- Output update: `tx_data_l/r` change exactly 2 `mclk` edges after the edge at which `ws` falls, and at no other time.
- Push latency: a pair accepted at edge N counts toward `level` after edge N and is poppable by a tick at N+1 or later.
- `playing` rises on the edge after `level` reaches PRIME_LEVEL.
- The `underrun` pulse coincides with the output update edge.
- Reset mid-frame: the FIFO content is lost and outputs go to 0 immediately. No requirement exists to re-align to the frame.

## Test plan
- Prime/start: HOLD_LAST=0, push 8 pairs (L=0x1000+i, R=0x2000+i) → `playing` rises after the 8th push. The first tick after that outputs 0x1000/0x2000, and ticks before it output 0/0.
- Ordering/wrap: push and consume 40 pairs continuously with DEPTH=16 → outputs appear in push order across pointer wrap, with no gaps or duplicates.
- Full: hold `in_valid`=1 with no ticks → `in_ready` falls when `level`=16, the 17th pair is not accepted, and `level` stays at 16.
- Underrun: HOLD_LAST=1, run the FIFO dry → on the first empty tick the outputs repeat the last pair, `underrun` pulses once, `underrun_cnt`=1 and `playing`=0. Refilling to 8 resumes playback.
- Stability: drive `ws` at a 64-sclk frame → for each `ws` edge N, `tx_data` does not change at edges N+0 or N+1. Changes occur only at falling-edge N+2.
- Flush: with `level`=5 and `underrun_cnt`=3, assert `flush` together with `in_valid` → `level`=0, the count is 0, state is PRIME, `tx_data` is unchanged, and the pair is not accepted.
